// File: rtl/persistence_integrator.sv
// Per-pixel, per-channel persistence integrator: saturating rise/fall levels held in a
// 2^ADDR_W-entry state memory. Optional PERSIST_SAT_FLAG_EN adds the out_sat flags.
module persistence_integrator #(
    parameter int unsigned CHANNELS  = 3,
    parameter int unsigned LEVEL_W   = 5,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned RISE_STEP = 1,
    parameter int unsigned FALL_STEP = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ADDR_W-1:0]             in_addr,
    input  logic [CHANNELS-1:0]           in_bits,
    output logic                          out_valid,
    output logic [ADDR_W-1:0]             out_addr,
    output logic [CHANNELS*LEVEL_W-1:0]   out_level
`ifdef PERSIST_SAT_FLAG_EN
    ,
    output logic [CHANNELS-1:0]           out_sat
`endif
);

    localparam int unsigned DEPTH     = 1 << ADDR_W;
    localparam int unsigned LVL_VEC_W = CHANNELS * LEVEL_W;
    // Wide enough that neither step parameter nor the level can wrap.
    localparam int unsigned ARITH_W   = ((LEVEL_W > 32) ? LEVEL_W : 32) + 1;
    localparam logic [ARITH_W-1:0] LVL_MAX = {{(ARITH_W-LEVEL_W){1'b0}}, {LEVEL_W{1'b1}}};

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   sweep_cnt, sweep_next;
    logic                ready_next;

    logic                s1_valid, s2_valid;
    logic [ADDR_W-1:0]   s1_addr, s2_addr;
    logic [CHANNELS-1:0] s1_bits, s2_bits;
    logic [LVL_VEC_W-1:0] s2_level;
    logic [LVL_VEC_W-1:0] new_level_c;
    logic                accept_c, fwd_c;

    logic [LVL_VEC_W-1:0] mem [0:DEPTH-1];

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= CLEAR;
            sweep_cnt <= '0;
            in_ready  <= 1'b0;
        end else begin
            state     <= state_next;
            sweep_cnt <= sweep_next;
            in_ready  <= ready_next;
        end
    end

    // Next-state: sweep every address once, then run
    always_comb begin
        state_next = state;
        sweep_next = sweep_cnt;
        case (state)
            CLEAR: begin
                sweep_next = sweep_cnt + ADDR_W'(1);
                if (sweep_cnt == {ADDR_W{1'b1}}) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: state_next = CLEAR;
        endcase
        ready_next = (state_next == RUN);
    end

    assign accept_c = in_valid && in_ready;
    // The update one stage ahead writes on the same edge we read, so bypass its result.
    assign fwd_c    = s2_valid && s1_valid && (s2_addr == s1_addr);

    // Per-channel saturating step
    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [ARITH_W-1:0] cur_c, up_c, res_c;
        assign cur_c = ARITH_W'(s2_level[k*LEVEL_W +: LEVEL_W]);
        assign up_c  = cur_c + ARITH_W'(RISE_STEP);
        assign res_c = s2_bits[k] ? ((up_c > LVL_MAX) ? LVL_MAX : up_c)
                                  : ((cur_c < ARITH_W'(FALL_STEP)) ? '0
                                                                   : cur_c - ARITH_W'(FALL_STEP));
        assign new_level_c[k*LEVEL_W +: LEVEL_W] = LEVEL_W'(res_c);
    end

`ifdef PERSIST_SAT_FLAG_EN
    logic [CHANNELS-1:0] sat_c;
    for (genvar k = 0; k < CHANNELS; k++) begin : g_sat
        assign sat_c[k] = (new_level_c[k*LEVEL_W +: LEVEL_W] == {LEVEL_W{1'b1}}) ||
                          (new_level_c[k*LEVEL_W +: LEVEL_W] == '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_sat <= '0;
        end else begin
            out_sat <= s2_valid ? sat_c : '0;
        end
    end
`endif

    // Accept -> read -> compute/write-back pipeline
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_addr   <= '0;
            s1_bits   <= '0;
            s2_valid  <= 1'b0;
            s2_addr   <= '0;
            s2_bits   <= '0;
            s2_level  <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_level <= '0;
        end else begin
            s1_valid  <= accept_c;
            s1_addr   <= in_addr;
            s1_bits   <= in_bits;
            s2_valid  <= s1_valid;
            s2_addr   <= s1_addr;
            s2_bits   <= s1_bits;
            s2_level  <= fwd_c ? new_level_c : mem[s1_addr];
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_addr  <= s2_addr;
                out_level <= new_level_c;
            end
        end
    end

    // State memory: cleared by the sweep, updated on the edge that raises out_valid
    always_ff @(posedge clock) begin
        if (state == CLEAR) begin
            mem[sweep_cnt] <= '0;
        end else if (s2_valid) begin
            mem[s2_addr] <= new_level_c;
        end
    end

endmodule
